// File: rtl/pht_pkg.sv
// Shared constants, saturating-counter helper and prediction bundle for the
// pattern history table.
package pht_pkg;

  localparam int unsigned PHT_CNT_W  = 2;
  localparam int unsigned PHT_IDX_W  = 4;
  localparam int unsigned PHT_PC_W   = 10;
  localparam int unsigned PHT_HIST_W = 0;

  // Widest counter/index the prediction bundle can carry.
  localparam int unsigned PHT_MAX_W  = 16;

  typedef struct packed {
    logic                 valid;
    logic                 taken;
    logic [PHT_MAX_W-1:0] cnt;
    logic [PHT_MAX_W-1:0] idx;
  } pht_pred_t;

  // The bound is checked before stepping, so the counter never wraps.
  function automatic logic [31:0] sat_next(input logic [31:0] cnt,
                                           input logic        taken,
                                           input logic [31:0] max);
    logic [31:0] res;
    res = cnt;
    if (taken && (cnt < max))
      res = cnt + 32'd1;
    else if (!taken && (cnt > 32'd0))
      res = cnt - 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/pht_sat_update.sv
// Combinational next-value unit for one saturating counter.
module pht_sat_update
  import pht_pkg::*;
#(
  parameter int unsigned CNT_W = PHT_CNT_W
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  assign cnt_next = CNT_W'(sat_next(32'(cnt), taken, CNT_MAX));

endmodule

// File: rtl/pattern_history_table.sv
// Table of saturating branch counters with registered prediction, training
// port, optional gshare history and single-cycle flush.
module pattern_history_table
  import pht_pkg::*;
#(
  parameter int unsigned CNT_W    = PHT_CNT_W,
  parameter int unsigned IDX_W    = PHT_IDX_W,
  parameter int unsigned PC_W     = PHT_PC_W,
  parameter int unsigned HIST_W   = PHT_HIST_W,
  parameter int unsigned INIT_VAL = 2 ** (CNT_W - 1)
) (
  input  logic                                PHT_CLK,
  input  logic                                PHT_RST_N,
  input  logic                                PHT_FLUSH,
  input  logic                                PHT_RD_EN,
  input  logic [PC_W-1:0]                     PHT_RD_PC,
  output logic                                PHT_PRED_VALID,
  output logic                                PHT_PRED_TAKEN,
  output logic [CNT_W-1:0]                    PHT_PRED_CNT,
  output logic [IDX_W-1:0]                    PHT_PRED_IDX,
  input  logic                                PHT_UPD_EN,
  input  logic [IDX_W-1:0]                    PHT_UPD_IDX,
  input  logic                                PHT_UPD_TAKEN,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] PHT_HIST
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned HW    = (HIST_W > 0) ? HIST_W : 1;
  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_VAL);

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [HW-1:0]    hist_q;
  logic [IDX_W-1:0] hist_ext;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] upd_next;
  pht_pred_t        pred_d;
  pht_pred_t        pred_q;

  if (HIST_W > 0) begin : g_gshare
    assign hist_ext = IDX_W'(hist_q);
  end else begin : g_bimodal
    assign hist_ext = '0;
  end

  assign rd_idx = PHT_RD_PC[IDX_W-1:0] ^ hist_ext;

  pht_sat_update #(.CNT_W(CNT_W)) u_sat_update (
    .cnt      (cnt_q[PHT_UPD_IDX]),
    .taken    (PHT_UPD_TAKEN),
    .cnt_next (upd_next)
  );

  // Same-cycle write-through: the prediction reflects what the table will
  // hold after this edge (flush value, or the freshly trained counter).
  always_comb begin
    rd_cnt = cnt_q[rd_idx];
    if (PHT_FLUSH)
      rd_cnt = INIT_CNT;
    else if (PHT_UPD_EN && (PHT_UPD_IDX == rd_idx))
      rd_cnt = upd_next;
    pred_d       = '0;
    pred_d.valid = 1'b1;
    pred_d.taken = rd_cnt[CNT_W-1];
    pred_d.cnt   = PHT_MAX_W'(rd_cnt);
    pred_d.idx   = PHT_MAX_W'(rd_idx);
  end

  always_ff @(posedge PHT_CLK) begin
    if (!PHT_RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        cnt_q[i] <= INIT_CNT;
      hist_q <= '0;
      pred_q <= '0;
    end else begin
      if (PHT_RD_EN)
        pred_q <= pred_d;
      else
        pred_q.valid <= 1'b0;

      if (PHT_FLUSH) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          cnt_q[i] <= INIT_CNT;
        hist_q <= '0;
      end else if (PHT_UPD_EN) begin
        cnt_q[PHT_UPD_IDX] <= upd_next;
        if (HIST_W > 0)
          hist_q <= HW'({hist_q, PHT_UPD_TAKEN});
      end
    end
  end

  assign PHT_PRED_VALID = pred_q.valid;
  assign PHT_PRED_TAKEN = pred_q.taken;
  assign PHT_PRED_CNT   = CNT_W'(pred_q.cnt);
  assign PHT_PRED_IDX   = IDX_W'(pred_q.idx);
  assign PHT_HIST       = hist_q;

endmodule

// File: tb/tb_pattern_history_table.sv
// Directed bench for pattern_history_table: a bimodal instance and a gshare
// (HIST_W=2) instance sharing clock and reset.
module tb_pattern_history_table;

  logic clk;
  logic rst_n;

  // bimodal instance
  logic       flush, rd_en, upd_en, upd_taken;
  logic [9:0] rd_pc;
  logic [3:0] upd_idx;
  logic       pred_valid, pred_taken;
  logic [1:0] pred_cnt;
  logic [3:0] pred_idx;
  logic [0:0] hist;

  // gshare instance
  logic       g_flush, g_rd_en, g_upd_en, g_upd_taken;
  logic [9:0] g_rd_pc;
  logic [3:0] g_upd_idx;
  logic       g_pred_valid, g_pred_taken;
  logic [1:0] g_pred_cnt;
  logic [3:0] g_pred_idx;
  logic [1:0] g_hist;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pattern_history_table u_dut (
    .PHT_CLK        (clk),
    .PHT_RST_N      (rst_n),
    .PHT_FLUSH      (flush),
    .PHT_RD_EN      (rd_en),
    .PHT_RD_PC      (rd_pc),
    .PHT_PRED_VALID (pred_valid),
    .PHT_PRED_TAKEN (pred_taken),
    .PHT_PRED_CNT   (pred_cnt),
    .PHT_PRED_IDX   (pred_idx),
    .PHT_UPD_EN     (upd_en),
    .PHT_UPD_IDX    (upd_idx),
    .PHT_UPD_TAKEN  (upd_taken),
    .PHT_HIST       (hist)
  );

  pattern_history_table #(.HIST_W(2)) u_dut_gs (
    .PHT_CLK        (clk),
    .PHT_RST_N      (rst_n),
    .PHT_FLUSH      (g_flush),
    .PHT_RD_EN      (g_rd_en),
    .PHT_RD_PC      (g_rd_pc),
    .PHT_PRED_VALID (g_pred_valid),
    .PHT_PRED_TAKEN (g_pred_taken),
    .PHT_PRED_CNT   (g_pred_cnt),
    .PHT_PRED_IDX   (g_pred_idx),
    .PHT_UPD_EN     (g_upd_en),
    .PHT_UPD_IDX    (g_upd_idx),
    .PHT_UPD_TAKEN  (g_upd_taken),
    .PHT_HIST       (g_hist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input logic [9:0] pc);
    rd_en = 1'b1;
    rd_pc = pc;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic upd_a(input logic [3:0] idx, input logic t);
    upd_en    = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic check_pred(input string tag, input logic [1:0] cnt, input logic [3:0] idx);
    check({tag, ".valid"}, 32'(pred_valid), 32'd1);
    check({tag, ".cnt"},   32'(pred_cnt),   32'(cnt));
    check({tag, ".taken"}, 32'(pred_taken), 32'(cnt[1]));
    check({tag, ".idx"},   32'(pred_idx),   32'(idx));
  endtask

  task automatic check_all_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      read_a(10'(i));
      check(tag, 32'(pred_cnt), 32'd2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {flush, rd_en, upd_en, upd_taken} = '0;
    rd_pc = '0; upd_idx = '0;
    {g_flush, g_rd_en, g_upd_en, g_upd_taken} = '0;
    g_rd_pc = '0; g_upd_idx = '0;

    // reset state
    tick();
    tick();
    check("rst.valid", 32'(pred_valid), 32'd0);
    check("rst.taken", 32'(pred_taken), 32'd0);
    check("rst.cnt",   32'(pred_cnt),   32'd0);
    check("rst.idx",   32'(pred_idx),   32'd0);
    check("rst.hist",  32'(g_hist),     32'd0);
    rst_n = 1'b1;

    // basic read, then valid drops and the rest hold
    read_a(10'h005);
    check_pred("rd5", 2'd2, 4'd5);
    tick();
    check("rd5.valid_drop", 32'(pred_valid), 32'd0);
    check("rd5.cnt_hold",   32'(pred_cnt),   32'd2);
    check("rd5.idx_hold",   32'(pred_idx),   32'd5);

    // saturation at both ends on idx 3
    for (int i = 0; i < 4; i++) upd_a(4'd3, 1'b1);
    read_a(10'h003);
    check_pred("sat_hi", 2'd3, 4'd3);
    for (int i = 0; i < 4; i++) upd_a(4'd3, 1'b0);
    read_a(10'h003);
    check_pred("sat_lo", 2'd0, 4'd3);
    upd_a(4'd3, 1'b0);
    read_a(10'h003);
    check_pred("sat_lo_hold", 2'd0, 4'd3);

    // write-through bypass on same index; upper PC bits ignored
    upd_en = 1'b1; upd_idx = 4'd7; upd_taken = 1'b0;
    rd_en  = 1'b1; rd_pc   = 10'h007;
    tick();
    upd_en = 1'b0; rd_en = 1'b0;
    check_pred("bypass", 2'd1, 4'd7);
    read_a(10'h3F7);
    check_pred("bypass_stored", 2'd1, 4'd7);

    // different indices are independent
    upd_en = 1'b1; upd_idx = 4'd8; upd_taken = 1'b1;
    rd_en  = 1'b1; rd_pc   = 10'h009;
    tick();
    upd_en = 1'b0; rd_en = 1'b0;
    check_pred("indep", 2'd2, 4'd9);
    read_a(10'h008);
    check_pred("indep_upd", 2'd3, 4'd8);

    // flush with concurrent update and read
    upd_a(4'd1, 1'b1);
    upd_a(4'd1, 1'b1);
    upd_a(4'd2, 1'b0);
    flush  = 1'b1;
    upd_en = 1'b1; upd_idx = 4'd1; upd_taken = 1'b0;
    rd_en  = 1'b1; rd_pc   = 10'h001;
    tick();
    flush = 1'b0; upd_en = 1'b0; rd_en = 1'b0;
    check_pred("flush_rd", 2'd2, 4'd1);
    check("flush.hist", 32'(hist), 32'd0);
    check_all_init("flush.entry");

    // gshare history and hashed index
    g_upd_en = 1'b1; g_upd_idx = 4'd0; g_upd_taken = 1'b1;
    tick();
    check("gs.hist1", 32'(g_hist), 32'd1);
    g_upd_taken = 1'b0;
    tick();
    g_upd_en = 1'b0;
    check("gs.hist2", 32'(g_hist), 32'd2);
    g_rd_en = 1'b1; g_rd_pc = 10'h004;
    tick();
    g_rd_en = 1'b0;
    check("gs.idx",   32'(g_pred_idx),   32'd6);
    check("gs.cnt",   32'(g_pred_cnt),   32'd2);
    check("gs.valid", 32'(g_pred_valid), 32'd1);
    g_flush = 1'b1;
    tick();
    g_flush = 1'b0;
    check("gs.flush_hist", 32'(g_hist), 32'd0);

    // reset in the middle of back-to-back traffic
    upd_a(4'd4, 1'b1);
    upd_a(4'd4, 1'b1);
    rd_en = 1'b1; upd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_pc = 10'(i + 4); upd_idx = 4'(i + 4); upd_taken = 1'b1;
      tick();
    end
    upd_idx = 4'd5; upd_taken = 1'b1;
    g_upd_en = 1'b1; g_upd_taken = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_en = 1'b0; upd_en = 1'b0; g_upd_en = 1'b0;
    check("mrst.valid", 32'(pred_valid), 32'd0);
    check("mrst.taken", 32'(pred_taken), 32'd0);
    check("mrst.cnt",   32'(pred_cnt),   32'd0);
    check("mrst.idx",   32'(pred_idx),   32'd0);
    check("mrst.hist",  32'(g_hist),     32'd0);
    check_all_init("mrst.entry");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_history_table.md
Name: pattern_history_table

Overview:
- Parametrised table of DEPTH saturating counters, the successor of the single 2-bit branch counter.
- Sits beside fetch: predicts taken/not-taken from the PC, and is trained by the branch-resolve stage.
- Optional gshare mode XORs a global history register into the index.
- Registered prediction (1-cycle latency), an update port, and a single-cycle flush.

Parameters:
- CNT_W, 2, counter width in bits (>=1).
- IDX_W, 4, log2 of table depth; DEPTH = 2**IDX_W.
- PC_W, 10, width of the PC input (>= IDX_W).
- HIST_W, 0, global history length; 0 = bimodal, otherwise gshare (1..IDX_W).
- INIT_VAL, 2**(CNT_W-1), counter value after reset/flush (weakly taken); must be < 2**CNT_W.

Ports:
- PHT_CLK  in  1  clock, all state on rising edge.
- PHT_RST_N  in  1  synchronous active-low reset.
- PHT_FLUSH  in  1  reinitialise all counters and history.
- PHT_RD_EN  in  1  prediction request.
- PHT_RD_PC  in  PC_W  PC of the branch to predict.
- PHT_PRED_VALID  out  1  prediction outputs valid this cycle.
- PHT_PRED_TAKEN  out  1  MSB of the selected counter.
- PHT_PRED_CNT  out  CNT_W  selected counter value.
- PHT_PRED_IDX  out  IDX_W  index used; the resolve stage returns it on update.
- PHT_UPD_EN  in  1  training request.
- PHT_UPD_IDX  in  IDX_W  entry to train.
- PHT_UPD_TAKEN  in  1  resolved direction.
- PHT_HIST  out  max(HIST_W,1)  current global history (0 when HIST_W=0).

Behaviour:
- Reset (PHT_RST_N=0 at the edge):
  - all counters = INIT_VAL, history = 0.
  - PHT_PRED_VALID = 0, PHT_PRED_TAKEN = 0, PHT_PRED_CNT = 0, PHT_PRED_IDX = 0.
  - Reset overrides every other input, including mid-stream reads and updates.
- Index:
  - rd_idx = PHT_RD_PC[IDX_W-1:0] XOR zero-extended history (pre-update value in the same cycle).
  - When HIST_W=0, rd_idx = PC bits only.
- Read, 1-cycle latency:
  - PHT_RD_EN=1 at edge N: PHT_PRED_* at edge N carry the counter at rd_idx; PHT_PRED_VALID=1 for that one cycle.
  - PHT_RD_EN=0: PHT_PRED_VALID=0; the other PHT_PRED_* outputs hold their last value.
- Update at edge:
  - Taken and cnt < 2**CNT_W-1: cnt+1.
  - Not taken and cnt > 0: cnt-1.
  - Otherwise hold; no wrap-around at either end.
  - History shifts left, PHT_UPD_TAKEN enters the LSB, oldest bit dropped (only when HIST_W>0).
- Read/update same index, same cycle: the prediction returns the post-update counter (write-through bypass). Different indices are independent.
- Flush at edge:
  - all counters = INIT_VAL, history = 0.
  - A concurrent update is discarded.
  - A concurrent read returns INIT_VAL with VALID=1; PHT_PRED_IDX is the pre-flush rd_idx.
- Priority: reset > flush > update. Reads are always serviced.
- Counter arithmetic is CNT_W bits unsigned; the saturation compare is made before add/subtract.
- Storage: flop array, DEPTH*CNT_W bits; no RAM inference required.

Decomposition:
- Package pht_pkg:
  - default parameter constants.
  - function sat_next(cnt, taken, max) returning the saturated next value.
  - typedef for the prediction bundle (valid, taken, cnt, idx).
- One sub-module: pht_sat_update, a combinational next-value unit (CNT_W parameter).
  - It is instanced once on the update path.
  - Its output also feeds the read bypass mux.

Test Plan:
- Reset then read PC=0x005 with defaults -> next cycle VALID=1, CNT=2, TAKEN=1, IDX=5; cycle after, VALID=0.
- Four taken updates to idx 3, then read -> CNT=3, TAKEN=1 (saturated at 3). Four not-taken updates -> CNT=0, TAKEN=0; a fifth not-taken -> CNT stays 0.
- Same-cycle update (idx 7, not taken) and read of PC=0x007 from a counter at 2 -> prediction CNT=1, TAKEN=0.
- HIST_W=2, updates taken, not-taken -> PHT_HIST=2'b10; read PC=0x004 -> IDX=4 XOR 2 = 6.
- Train several entries, assert PHT_FLUSH with PHT_UPD_EN (idx 1) and PHT_RD_EN -> prediction CNT=2; then all entries read 2, PHT_HIST=0.
- PHT_RST_N=0 for one cycle during back-to-back reads/updates -> VALID=0, all outputs 0, every counter reads INIT_VAL afterwards.
